traffic_phase_sequencer: RTL and testbench

//  Parametrised traffic-light phase sequencer: steps through N_PHASES phases, each held for a

---
 rtl/traffic_pkg.sv | 73 +++++++
 rtl/traffic_phase_sequencer_if.sv | 38 +++
 rtl/phase_timer.sv | 41 ++++
 rtl/traffic_phase_sequencer.sv | 133 +++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer.
//   - lamp encodings for one 2-bit signal head
//   - controller mode enum, which is also the FSM state visible on the mode output
//   - default lamp pattern per phase, held as one row of four heads {h3,h2,h1,h0}
//   - default phase durations in go-cycles
// Phase 0 of the default cycle is all-red. Power-up and every mode exit land on phase 0.
package traffic_pkg;

  localparam logic [1:0] SIG_GREEN      = 2'b00;
  localparam logic [1:0] SIG_YELLOW     = 2'b01;
  localparam logic [1:0] SIG_RED        = 2'b10;
  localparam logic [1:0] SIG_RED_YELLOW = 2'b11;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_EMERG  = 2'b01,
    MODE_NIGHT  = 2'b10
  } mode_e;

  // One row per phase. Heads 0/1 form one approach and heads 2/3 the crossing approach.
  // Any phase outside the table shows all-red.
  function automatic logic [7:0] pattern_row(input int unsigned ph);
    logic [7:0] row;
    case (ph)
      0:       row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_RED};
      1:       row = {SIG_RED,        SIG_RED,        SIG_RED_YELLOW, SIG_RED_YELLOW};
      2:       row = {SIG_RED,        SIG_RED,        SIG_GREEN,      SIG_GREEN};
      3:       row = {SIG_RED,        SIG_RED,        SIG_YELLOW,     SIG_YELLOW};
      4:       row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_GREEN};
      5:       row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_YELLOW};
      6:       row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_RED};
      7:       row = {SIG_RED_YELLOW, SIG_RED_YELLOW, SIG_RED,        SIG_RED};
      8:       row = {SIG_GREEN,      SIG_GREEN,      SIG_RED,        SIG_RED};
      9:       row = {SIG_YELLOW,     SIG_YELLOW,     SIG_RED,        SIG_RED};
      10:      row = {SIG_RED,        SIG_GREEN,      SIG_RED,        SIG_RED};
      11:      row = {SIG_RED,        SIG_YELLOW,     SIG_RED,        SIG_RED};
      12:      row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_RED};
      13:      row = {SIG_RED_YELLOW, SIG_RED,        SIG_RED_YELLOW, SIG_RED};
      14:      row = {SIG_GREEN,      SIG_RED,        SIG_GREEN,      SIG_RED};
      15:      row = {SIG_YELLOW,     SIG_RED,        SIG_YELLOW,     SIG_RED};
      16:      row = {SIG_RED,        SIG_RED,        SIG_GREEN,      SIG_RED};
      17:      row = {SIG_RED,        SIG_RED,        SIG_YELLOW,     SIG_RED};
      default: row = {SIG_RED,        SIG_RED,        SIG_RED,        SIG_RED};
    endcase
    return row;
  endfunction

  // When there are more than four heads, head i repeats the pattern of head i mod 4.
  function automatic logic [1:0] pattern_head(input int unsigned ph, input int unsigned head);
    logic [7:0] row;
    logic [1:0] code;
    row = pattern_row(ph);
    case (head % 4)
      0:       code = row[1:0];
      1:       code = row[3:2];
      2:       code = row[5:4];
      default: code = row[7:6];
    endcase
    return code;
  endfunction

  function automatic int unsigned default_dur(input int unsigned ph);
    int unsigned d;
    case (ph)
      0: d = 1;   1: d = 2;   2: d = 30;  3: d = 2;   4: d = 10;  5: d = 2;
      6: d = 1;   7: d = 2;   8: d = 15;  9: d = 2;   10: d = 5;  11: d = 2;
      12: d = 10; 13: d = 2;  14: d = 10; 15: d = 2;  16: d = 15; 17: d = 3;
      default: d = 1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the intersection timebase, the configuration port and the
// sequencer.
//   inputs to the sequencer : go, emerg, night, cfg_we, cfg_addr, cfg_dur
//   outputs of the sequencer: sig, phase, count, phase_done, mode
// There is no valid/ready handshake in this bundle. go qualifies a clock edge as a
// timebase tick. emerg and night are levels that are sampled on every edge. cfg_we is a
// single-edge write strobe that is always accepted, so it has no backpressure.
// The master modport is the environment side and the slave modport is the sequencer.
interface traffic_phase_sequencer_if #(
  parameter int NUM_SIG = 4,
  parameter int PW      = 5,
  parameter int CW      = 5
);
  import traffic_pkg::*;

  logic                 go;
  logic                 emerg;
  logic                 night;
  logic                 cfg_we;
  logic [PW-1:0]        cfg_addr;
  logic [CW-1:0]        cfg_dur;
  logic [2*NUM_SIG-1:0] sig;
  logic [PW-1:0]        phase;
  logic [CW-1:0]        count;
  logic                 phase_done;
  mode_e                mode;

  modport master (
    output go, emerg, night, cfg_we, cfg_addr, cfg_dur,
    input  sig, phase, count, phase_done, mode
  );

  modport slave (
    input  go, emerg, night, cfg_we, cfg_addr, cfg_dur,
    output sig, phase, count, phase_done, mode
  );

endinterface

// File: rtl/phase_timer.sv
// Go-gated dwell counter with a programmable limit.
//   clk, Rst_n : clock and asynchronous active-low reset
//   enable     : timebase tick. The counter moves only when this is 1.
//   clear      : forces the count to 0 and takes priority over enable
//   limit      : dwell length in ticks. A limit of 0 is treated as 1.
//   count      : ticks elapsed in the current dwell
//   terminal   : combinational. It is 1 on a tick that ends the dwell.
// The compare is >= rather than ==. A limit reprogrammed below the current count
// therefore ends the dwell on the next tick, and the counter never wraps.
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          Rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] last_tick;
  logic          at_end;

  // Index of the final tick of the dwell (effective duration minus one).
  assign last_tick = (limit == '0) ? '0 : limit - CW'(1);
  assign at_end    = (count >= last_tick);
  assign terminal  = enable && at_end;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (at_end) count <= '0;
      else        count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Traffic-light phase sequencer.
//   clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset. It forces all-red, phase 0, count 0 and
//           NORMAL mode at once, and it reloads the default duration table.
//   bus   : slave side of traffic_phase_sequencer_if (go, emerg, night, cfg_* in;
//           sig, phase, count, phase_done, mode out)
// The mode register is the FSM state. It is visible directly on bus.mode.
// Every output is registered. sig is decoded from the next state so that it changes on
// the same edge as phase and mode.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_SIG    = 4,
  parameter int N_PHASES   = 18,
  parameter int CW         = 5,
  parameter int PW         = 5,
  parameter int FLASH_HALF = 1
) (
  input logic                      clk,
  input logic                      Rst_n,
  traffic_phase_sequencer_if.slave bus
);

  localparam logic [PW-1:0]        LAST_PHASE = PW'(N_PHASES - 1);
  localparam logic [CW-1:0]        FLASH_LIM  = CW'(FLASH_HALF);
  localparam logic [2*NUM_SIG-1:0] ALL_RED    = {NUM_SIG{SIG_RED}};
  localparam logic [2*NUM_SIG-1:0] ALL_YELLOW = {NUM_SIG{SIG_YELLOW}};

  logic [CW-1:0]        dur_q [N_PHASES];
  mode_e                mode_q, mode_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 flash_red_q, flash_red_d;
  logic                 done_q, done_d;
  logic [2*NUM_SIG-1:0] sig_q, sig_d, norm_sig;
  logic                 mode_change;
  logic                 timer_clear, tick;
  logic [CW-1:0]        timer_limit, count;

  // Duration table. Writes to addresses outside the phase range are dropped.
  // The terminal check on this edge still sees the old entry.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < N_PHASES; i++) dur_q[i] <= CW'(default_dur(i));
    end else if (bus.cfg_we && (bus.cfg_addr <= LAST_PHASE)) begin
      dur_q[bus.cfg_addr] <= bus.cfg_dur;
    end
  end

  // Mode request priority: emerg > night > normal. No go tick is needed to change mode.
  always_comb begin
    mode_d = MODE_NORMAL;
    if (bus.emerg)      mode_d = MODE_EMERG;
    else if (bus.night) mode_d = MODE_NIGHT;
  end

  assign mode_change = (mode_d != mode_q);

  // One counter serves as the phase dwell timer in NORMAL and as the flash
  // half-period timer in NIGHT. It is held at 0 in EMERG and on any mode change.
  assign timer_limit = (mode_q == MODE_NIGHT) ? FLASH_LIM : dur_q[phase_q];
  assign timer_clear = mode_change || (mode_q == MODE_EMERG);

  phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .enable   (bus.go),
    .clear    (timer_clear),
    .limit    (timer_limit),
    .count    (count),
    .terminal (tick)
  );

  always_comb begin
    phase_d     = phase_q;
    flash_red_d = flash_red_q;
    done_d      = 1'b0;
    if (mode_change) begin
      // Every mode entry or exit restarts at phase 0. NIGHT starts on yellow.
      phase_d     = '0;
      flash_red_d = 1'b0;
    end else begin
      case (mode_q)
        MODE_NORMAL: begin
          if (tick) begin
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
            done_d  = 1'b1;
          end
        end
        MODE_NIGHT: begin
          phase_d = '0;
          if (tick) flash_red_d = ~flash_red_q;
        end
        default: phase_d = '0;
      endcase
    end
  end

  for (genvar h = 0; h < NUM_SIG; h++) begin : g_head
    assign norm_sig[2*h +: 2] = pattern_head(32'(phase_d), h);
  end

  always_comb begin
    sig_d = ALL_RED;
    case (mode_d)
      MODE_NORMAL: sig_d = norm_sig;
      MODE_NIGHT:  sig_d = flash_red_d ? ALL_RED : ALL_YELLOW;
      default:     sig_d = ALL_RED;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q      <= MODE_NORMAL;
      phase_q     <= '0;
      flash_red_q <= 1'b0;
      done_q      <= 1'b0;
      sig_q       <= ALL_RED;
    end else begin
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      flash_red_q <= flash_red_d;
      done_q      <= done_d;
      sig_q       <= sig_d;
    end
  end

  assign bus.sig        = sig_q;
  assign bus.phase      = phase_q;
  assign bus.count      = count;
  assign bus.phase_done = done_q;
  assign bus.mode       = mode_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Testbench for traffic_phase_sequencer. It applies directed steps and then random
// stimulus, and it checks every output against a behavioural reference model on
// every clock.
module tb_traffic_phase_sequencer;

  localparam int NUM_SIG  = 4;
  localparam int N_PHASES = 18;
  localparam int CW       = 5;
  localparam int PW       = 5;
  localparam int FH       = 1;

  localparam logic [7:0] RED8    = 8'hAA;
  localparam logic [7:0] YELLOW8 = 8'h55;

  logic clk;
  logic Rst_n;

  traffic_phase_sequencer_if #(.NUM_SIG(NUM_SIG), .PW(PW), .CW(CW)) bus ();

  traffic_phase_sequencer #(
    .NUM_SIG(NUM_SIG), .N_PHASES(N_PHASES), .CW(CW), .PW(PW), .FLASH_HALF(FH)
  ) dut (
    .clk   (clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Lamp rows {h3,h2,h1,h0}. G=00, Y=01, R=10, RY=11.
  logic [7:0] ref_pat [N_PHASES];
  int         ref_dur [N_PHASES];
  int m_mode;   // 0 normal, 1 emergency, 2 night
  int m_phase;
  int m_count;  // go-cycles spent in the current phase (normal) or flash half (night)
  int m_done;
  int m_ngos;   // go-cycles seen since night mode was entered

  int n_cmp;
  int n_fail;
  int n_pulses;

  task automatic model_reset();
    ref_pat = '{8'hAA, 8'hAF, 8'hA0, 8'hA5, 8'hA8, 8'hA9, 8'hAA, 8'hFA, 8'h0A,
                8'h5A, 8'h8A, 8'h9A, 8'hAA, 8'hEE, 8'h22, 8'h66, 8'hA2, 8'hA6};
    ref_dur = '{1, 2, 30, 2, 10, 2, 1, 2, 15, 2, 5, 2, 10, 2, 10, 2, 15, 3};
    m_mode  = 0;
    m_phase = 0;
    m_count = 0;
    m_done  = 0;
    m_ngos  = 0;
  endtask

  // One clock edge. A phase is held for max(dur,1) go-cycles. A configuration write
  // lands after this edge's dwell decision.
  task automatic model_step(input logic go, input logic emerg, input logic night,
                            input logic we, input int addr, input int dur);
    int req;
    int hold;
    req    = emerg ? 1 : (night ? 2 : 0);
    m_done = 0;
    if (req != m_mode) begin
      m_mode  = req;
      m_phase = 0;
      m_count = 0;
      m_ngos  = 0;
    end else if (m_mode == 0 && go) begin
      hold = (ref_dur[m_phase] == 0) ? 1 : ref_dur[m_phase];
      if (m_count + 1 >= hold) begin
        m_phase = (m_phase + 1) % N_PHASES;
        m_count = 0;
        m_done  = 1;
      end else begin
        m_count = m_count + 1;
      end
    end else if (m_mode == 2 && go) begin
      m_ngos  = m_ngos + 1;
      m_count = m_ngos % FH;
    end
    if (we && addr < N_PHASES) ref_dur[addr] = dur;
  endtask

  function automatic logic [7:0] exp_sig();
    if (m_mode == 1)      return RED8;
    else if (m_mode == 2) return (((m_ngos / FH) % 2) == 0) ? YELLOW8 : RED8;
    else                  return ref_pat[m_phase];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":sig"},   32'(bus.sig),        32'(exp_sig()));
    check({tag, ":phase"}, 32'(bus.phase),      m_phase);
    check({tag, ":count"}, 32'(bus.count),      m_count);
    check({tag, ":done"},  32'(bus.phase_done), m_done);
    check({tag, ":mode"},  32'(bus.mode),       m_mode);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic go, input logic emerg, input logic night,
                      input logic we, input int addr, input int dur, input string tag);
    bus.go       = go;
    bus.emerg    = emerg;
    bus.night    = night;
    bus.cfg_we   = we;
    bus.cfg_addr = PW'(addr);
    bus.cfg_dur  = CW'(dur);
    @(posedge clk);
    model_step(go, emerg, night, we, addr, dur);
    #1;
    check_all(tag);
    if (bus.phase_done === 1'b1) n_pulses++;
  endtask

  // Apply steady go until the model reaches phase ph with count cnt. The wait is bounded.
  task automatic run_to(input int ph, input int cnt, input string tag);
    int k;
    k = 0;
    while (!(m_mode == 0 && m_phase == ph && m_count == cnt) && k < 700) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, tag);
      k++;
    end
    check({tag, ":reached"}, 32'(k < 700), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic r_emerg;
  logic r_night;

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    n_pulses = 0;
    model_reset();
    Rst_n        = 1'b0;
    bus.go       = 1'b0;
    bus.emerg    = 1'b0;
    bus.night    = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_dur  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    Rst_n = 1'b1;

    // 1: steady go over one full cycle of the default table.
    for (int i = 0; i < 116; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t1_steady");
    check("t1_cycle_phase", 32'(bus.phase), 32'd0);
    check("t1_pulses", n_pulses, 18);

    // 2: go toggled every clock. The count freezes while go is low.
    for (int i = 0; i < 40; i++) step(((i % 2) == 0), 1'b0, 1'b0, 1'b0, 0, 0, "t2_toggle");

    // 3: emergency raised during the green of phase 2, then released.
    run_to(2, 5, "t3_seek");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t3_emerg");
    check("t3_emerg_sig", 32'(bus.sig), 32'(RED8));
    check("t3_emerg_mode", 32'(bus.mode), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "t3_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t3_release");
    check("t3_rel_phase", 32'(bus.phase), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t3_after");
    check("t3_phase1", 32'(bus.phase), 32'd1);

    // 4: night flashing, overridden by emergency, then back to normal.
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "t4_enter");
    check("t4_first_yellow", 32'(bus.sig), 32'(YELLOW8));
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "t4_flash");
    check("t4_then_red", 32'(bus.sig), 32'(RED8));
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "t4_nogo");
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "t4_flash");
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "t4_override");
    check("t4_override_mode", 32'(bus.mode), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "t4_renight");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t4_exit");

    // 5: runtime duration writes, including zero and an out-of-range address.
    run_to(2, 10, "t5_seek");
    step(1'b0, 1'b0, 1'b0, 1'b1, 2, 3, "t5_shrink");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t5_endnow");
    check("t5_phase3", 32'(bus.phase), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5, 0, "t5_zero");
    run_to(5, 0, "t5_seek5");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t5_zero_len");
    check("t5_phase6", 32'(bus.phase), 32'd6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 20, 7, "t5_badaddr");
    for (int i = 0; i < 110; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t5_cycle");

    // 6: asynchronous reset in the middle of phase 8, away from any clock edge.
    run_to(8, 4, "t6_seek");
    #1;
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    #1;
    check_all("t6_held");
    Rst_n = 1'b1;

    // 7: random mix of ticks, mode requests and configuration writes.
    r_emerg = 1'b0;
    r_night = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r_emerg = ~r_emerg;
      if ($urandom_range(0, 14) == 0) r_night = ~r_night;
      step(($urandom_range(0, 9) < 7), r_emerg, r_night, ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "t7_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
